// File: rtl/hermes_input_buffer_if.sv
// Hermes input buffer port bundle: upstream credit link, routing request and crossbar handshake.
interface hermes_input_buffer_if #(
  parameter int unsigned FLIT_SIZE = 32
);
  logic                 rx_i;
  logic [FLIT_SIZE-1:0] data_i;
  logic                 credit_o;
  logic                 req_routing_o;
  logic                 ack_routing_i;
  logic                 sending_o;
  logic                 req_o;
  logic [FLIT_SIZE-1:0] data_o;
  logic                 ack_i;

  // Buffer side
  modport slave (
    input  rx_i, data_i, ack_routing_i, ack_i,
    output credit_o, req_routing_o, sending_o, req_o, data_o
  );

  // Neighbour / switch-control / crossbar side
  modport master (
    output rx_i, data_i, ack_routing_i, ack_i,
    input  credit_o, req_routing_o, sending_o, req_o, data_o
  );
endinterface

// File: rtl/hermes_input_buffer.sv
// Hermes router per-port input FIFO with packet framing FSM.
// Optional macro HERMES_BUFFER_STATS_EN adds a saturating completed-packet counter (pkt_cnt_o).
module hermes_input_buffer #(
  parameter int unsigned FLIT_SIZE   = 32,
  parameter int unsigned BUFFER_SIZE = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef HERMES_BUFFER_STATS_EN
  output logic [15:0]           pkt_cnt_o,
`endif
  hermes_input_buffer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
  localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);

  typedef enum logic [2:0] {IDLE, REQ, HEADER, SIZE, PAYLOAD} state_e;

  state_e               state_q, state_d;
  logic [FLIT_SIZE-1:0] size_q, size_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];

  logic                 empty, full, push, pop, in_xfer;
  logic                 req_routing, sending, pkt_done;
  logic [FLIT_SIZE-1:0] head;

  assign empty   = (count_q == CNT_W'(0));
  assign full    = (count_q == CNT_W'(BUFFER_SIZE));
  assign head    = mem_q[rd_ptr_q];
  assign in_xfer = (state_q == HEADER) || (state_q == SIZE) || (state_q == PAYLOAD);
  assign push    = bus.rx_i && !full;
  assign pop     = in_xfer && !empty && bus.ack_i;

  assign bus.credit_o      = !full;
  assign bus.req_o         = in_xfer && !empty;
  assign bus.data_o        = empty ? '0 : head;
  assign bus.req_routing_o = req_routing;
  assign bus.sending_o     = sending;

  // Packet framing: route request, then header, size, and N payload pops
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    req_routing = 1'b0;
    sending     = 1'b0;
    pkt_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = REQ;
      end
      REQ: begin
        req_routing = 1'b1;
        if (bus.ack_routing_i) state_d = HEADER;
      end
      HEADER: begin
        sending = 1'b1;
        if (pop) state_d = SIZE;
      end
      SIZE: begin
        sending = 1'b1;
        if (pop) begin
          size_d = head;
          if (head == '0) begin
            state_d  = IDLE;
            pkt_done = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        sending = 1'b1;
        if (pop) begin
          size_d = size_q - FLIT_SIZE'(1);
          if (size_q == FLIT_SIZE'(1)) begin
            state_d  = IDLE;
            pkt_done = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; pointers wrap at the power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      size_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flit storage; contents are don't-care while the slot is not counted as occupied
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_i;
  end

`ifdef HERMES_BUFFER_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  // Saturating count of completed packets
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_done && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_d = pkt_cnt_q + 16'(1);
  end

  // Packet counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pkt_cnt_q <= '0;
    else         pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt_o = pkt_cnt_q;
`else
  logic unused_pkt_done;
  assign unused_pkt_done = pkt_done;
`endif

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Self-checking bench for hermes_input_buffer: cycle table for one packet plus corner-case sequences.
module tb_hermes_input_buffer;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  hermes_input_buffer_if #(.FLIT_SIZE(32)) bus ();

`ifdef HERMES_BUFFER_STATS_EN
  logic [15:0] pkt_cnt_o;
`endif

  hermes_input_buffer #(.FLIT_SIZE(32), .BUFFER_SIZE(8)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
`ifdef HERMES_BUFFER_STATS_EN
    .pkt_cnt_o (pkt_cnt_o),
`endif
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] sb [$];

  typedef struct {
    logic        rx;
    logic [31:0] din;
    logic        ack_r;
    logic        ack;
    logic        exp_credit;
    logic        exp_req_r;
    logic        exp_sending;
    logic        exp_req;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl [10];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, score the crossbar transfer / accepted write, advance past the edge
  task automatic step(input logic rx, input logic [31:0] d, input logic ar, input logic ak);
    bus.rx_i          = rx;
    bus.data_i        = d;
    bus.ack_routing_i = ar;
    bus.ack_i         = ak;
    if (bus.req_o && ak) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: got pop of 0x%0h expected no transfer", bus.data_o);
      end else begin
        chkw("sb_data", bus.data_o, sb.pop_front());
      end
    end
    if (rx && bus.credit_o) sb.push_back(d);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    bus.rx_i = 1'b0; bus.data_i = '0; bus.ack_routing_i = 1'b0; bus.ack_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    sb.delete();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk1({nm, "_credit"},  bus.credit_o,      1'b1);
    chk1({nm, "_req_r"},   bus.req_routing_o, 1'b0);
    chk1({nm, "_sending"}, bus.sending_o,     1'b0);
    chk1({nm, "_req"},     bus.req_o,         1'b0);
    chkw({nm, "_data"},    bus.data_o,        32'h0);
  endtask

  task automatic wait_req_routing();
    int n = 0;
    while (!bus.req_routing_o && n < 10) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      n++;
    end
    chk1("wait_req_routing", bus.req_routing_o, 1'b1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      n++;
    end
    chkw(nm, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    //            rx    din      ar    ack   cr    rr    snd   req   dout
    tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11};
    tbl[2] = '{1'b1, 32'hA,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11};
    tbl[3] = '{1'b1, 32'hB,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11};
    tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11};
    tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2};
    tbl[7] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA};
    tbl[8] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB};
    tbl[9] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    // Reset state
    do_reset();
    chk_idle("reset");
`ifdef HERMES_BUFFER_STATS_EN
    chkw("reset_pkt_cnt", 32'(pkt_cnt_o), 32'h0);
`endif

    // Single packet, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      chk1($sformatf("t%0d_credit", i),  bus.credit_o,      tbl[i].exp_credit);
      chk1($sformatf("t%0d_req_r", i),   bus.req_routing_o, tbl[i].exp_req_r);
      chk1($sformatf("t%0d_sending", i), bus.sending_o,     tbl[i].exp_sending);
      chk1($sformatf("t%0d_req", i),     bus.req_o,         tbl[i].exp_req);
      chkw($sformatf("t%0d_data", i),    bus.data_o,        tbl[i].exp_dout);
      step(tbl[i].rx, tbl[i].din, tbl[i].ack_r, tbl[i].ack);
    end
    chkw("pkt1_sb_empty", 32'(sb.size()), 32'h0);
`ifdef HERMES_BUFFER_STATS_EN
    chkw("pkt1_pkt_cnt", 32'(pkt_cnt_o), 32'h1);
`endif

    // Fill to depth, overflow write dropped, one pop restores credit
    do_reset();
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h6,   1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    chk1("full_credit", bus.credit_o, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk1("overflow_credit", bus.credit_o, 1'b0);
    chk1("full_req_r", bus.req_routing_o, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk1("full_sending", bus.sending_o, 1'b1);
    chk1("full_req", bus.req_o, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("after_pop_credit", bus.credit_o, 1'b1);
    drain("full_drain");
    chk_idle("full_end");

    // Size-zero packet
    do_reset();
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h0,  1'b0, 1'b0);
    wait_req_routing();
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("sz0_size_req", bus.req_o, 1'b1);
    chkw("sz0_size_data", bus.data_o, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("sz0_sending", bus.sending_o, 1'b0);
    chk1("sz0_no_payload_req", bus.req_o, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_idle("sz0_end");
`ifdef HERMES_BUFFER_STATS_EN
    chkw("sz0_pkt_cnt", 32'(pkt_cnt_o), 32'h1);
`endif

    // Back-to-back packets
    do_reset();
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'hD, 1'b0, 1'b0);
    wait_req_routing();
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chkw("b2b_last_data", bus.data_o, 32'hC);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("b2b_gap_sending", bus.sending_o, 1'b0);
    chk1("b2b_gap_req_r", bus.req_routing_o, 1'b0);
    chk1("b2b_gap_req", bus.req_o, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("b2b_second_req_r", bus.req_routing_o, 1'b1);
    chk1("b2b_second_sending", bus.sending_o, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk1("b2b_second_grant_sending", bus.sending_o, 1'b1);
    drain("b2b_drain");
    chk_idle("b2b_end");
`ifdef HERMES_BUFFER_STATS_EN
    chkw("b2b_pkt_cnt", 32'(pkt_cnt_o), 32'h2);
`endif

    // Reset mid-payload with 3 flits buffered
    do_reset();
    step(1'b1, 32'h5,  1'b0, 1'b0);
    step(1'b1, 32'h5,  1'b0, 1'b0);
    step(1'b1, 32'h51, 1'b0, 1'b0);
    step(1'b1, 32'h52, 1'b0, 1'b0);
    step(1'b1, 32'h53, 1'b0, 1'b0);
    step(1'b1, 32'h54, 1'b0, 1'b0);
    wait_req_routing();
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk1("mid_sending", bus.sending_o, 1'b1);
    chkw("mid_data", bus.data_o, 32'h52);
    bus.ack_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk_idle("async_rst");
    do_reset();
    chk_idle("post_rst");
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_idle("post_rst_quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
